// File: rtl/demux_stream_1x4_if.sv
// rtl/demux_stream_1x4_if.sv - handshake bundle for the 1x4 stream demultiplexer
interface demux_stream_1x4_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [1:0]            in_sel;
    logic                  mode;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [4*DATA_W-1:0]   out_data;

    // Producer/consumer side: drives the input word and the per-channel ready
    modport master (
        output in_valid, in_data, in_sel, mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Demultiplexer side
    modport slave (
        input  in_valid, in_data, in_sel, mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream_1x4.sv
// rtl/demux_stream_1x4.sv - registered 1-to-4 stream demux with explicit or round-robin channel select
module demux_stream_1x4 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_stream_1x4_if.slave    bus,
    output logic [1:0]           rr_ptr,
    output logic [CNT_W-1:0]     xfer_cnt
);

    logic [3:0]          out_valid_q, out_valid_d;
    logic [4*DATA_W-1:0] out_data_q,  out_data_d;
    logic [1:0]          rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]    xfer_cnt_q,  xfer_cnt_d;

    logic [1:0] tgt;
    logic [3:0] slot_free;
    logic       acc;

    // Target selection and readiness; in_ready never looks at in_valid
    always_comb begin
        tgt          = bus.mode ? rr_ptr_q : bus.in_sel;
        slot_free    = ~out_valid_q | bus.out_ready;
        bus.in_ready = slot_free[tgt];
        acc          = bus.in_valid && bus.in_ready;
    end

    // Next state: drain every consumed slot, then refill the target on accept
    always_comb begin
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (acc) begin
            out_valid_d[tgt]                       = 1'b1;
            out_data_d[int'(tgt)*DATA_W +: DATA_W] = bus.in_data;
            xfer_cnt_d                             = xfer_cnt_q + 1'b1;
            if (bus.mode) begin
                rr_ptr_d = rr_ptr_q + 2'd1;
            end
        end
    end

    // State registers; reset discards any held words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign rr_ptr        = rr_ptr_q;
    assign xfer_cnt      = xfer_cnt_q;

endmodule

// File: tb/tb_demux_stream_1x4.sv
// tb/tb_demux_stream_1x4.sv - directed self-checking bench for demux_stream_1x4
module tb_demux_stream_1x4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rr_ptr;
    logic [15:0] xfer_cnt;
    logic [1:0]  rr_ptr_w;
    logic [3:0]  xfer_cnt_w;

    int total;
    int bad;

    demux_stream_1x4_if #(.DATA_W(8)) bus ();
    demux_stream_1x4_if #(.DATA_W(8)) bus_w ();

    demux_stream_1x4 #(.DATA_W(8), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .rr_ptr   (rr_ptr),
        .xfer_cnt (xfer_cnt)
    );

    demux_stream_1x4 #(.DATA_W(8), .CNT_W(4)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_w.slave),
        .rr_ptr   (rr_ptr_w),
        .xfer_cnt (xfer_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ch(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_data = 0; bus.in_sel = 0; bus.mode = 0; bus.out_ready = 4'h0;
        bus_w.in_valid = 0; bus_w.in_data = 0; bus_w.in_sel = 0; bus_w.mode = 0; bus_w.out_ready = 4'h0;
        step();
        step();
        rst_n = 1'b1;
        total++; if (bus.out_valid !== 4'h0) begin bad++; $display("FAIL reset_out_valid got=%h exp=0", bus.out_valid); end
        total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        total++; if (rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_rr_ptr got=%0d exp=0", rr_ptr); end
        total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
    endtask

    task automatic test_explicit();
        bus.mode = 1'b0;
        bus.out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA0 + 8'(k);
            bus.in_sel   = 2'(k);
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL explicit_in_ready k=%0d got=%b exp=1", k, bus.in_ready); end
            step();
            total++; if (bus.out_valid !== (4'b0001 << k)) begin bad++; $display("FAIL explicit_valid k=%0d got=%b exp=%b", k, bus.out_valid, 4'b0001 << k); end
            total++; if (ch(bus.out_data, k) !== 8'hA0 + 8'(k)) begin bad++; $display("FAIL explicit_data k=%0d got=%h exp=%h", k, ch(bus.out_data, k), 8'hA0 + 8'(k)); end
        end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.out_valid !== 4'h0) begin bad++; $display("FAIL explicit_drain got=%b exp=0000", bus.out_valid); end
        total++; if (xfer_cnt !== 16'd4) begin bad++; $display("FAIL explicit_cnt got=%0d exp=4", xfer_cnt); end
        total++; if (rr_ptr !== 2'd0) begin bad++; $display("FAIL explicit_rr got=%0d exp=0", rr_ptr); end
    endtask

    task automatic test_stall();
        bus.mode = 1'b0;
        bus.out_ready = 4'b1011;
        bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_sel = 2'd2;
        step();
        total++; if (bus.out_valid !== 4'b0100) begin bad++; $display("FAIL stall_load got=%b exp=0100", bus.out_valid); end
        bus.in_data = 8'h66; bus.in_sel = 2'd2;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
        step();
        total++; if (ch(bus.out_data, 2) !== 8'h55) begin bad++; $display("FAIL stall_hold got=%h exp=55", ch(bus.out_data, 2)); end
        bus.in_data = 8'h77; bus.in_sel = 2'd1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_other_ready got=%b exp=1", bus.in_ready); end
        step();
        total++; if (bus.out_valid !== 4'b0110) begin bad++; $display("FAIL stall_other_valid got=%b exp=0110", bus.out_valid); end
        total++; if (ch(bus.out_data, 1) !== 8'h77) begin bad++; $display("FAIL stall_other_data got=%h exp=77", ch(bus.out_data, 1)); end
        bus.in_data = 8'h66; bus.in_sel = 2'd2; bus.out_ready = 4'hF;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready); end
        step();
        total++; if (bus.out_valid !== 4'b0100) begin bad++; $display("FAIL stall_refill_valid got=%b exp=0100", bus.out_valid); end
        total++; if (ch(bus.out_data, 2) !== 8'h66) begin bad++; $display("FAIL stall_refill_data got=%h exp=66", ch(bus.out_data, 2)); end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.out_valid !== 4'h0) begin bad++; $display("FAIL stall_drain got=%b exp=0000", bus.out_valid); end
        total++; if (xfer_cnt !== 16'd7) begin bad++; $display("FAIL stall_cnt got=%0d exp=7", xfer_cnt); end
    endtask

    task automatic test_round_robin();
        bus.mode = 1'b1;
        bus.out_ready = 4'hF;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h10 + 8'(k);
            bus.in_sel   = 2'($urandom_range(0, 3));
            step();
            total++; if (bus.out_valid !== (4'b0001 << (k % 4))) begin bad++; $display("FAIL rr_valid k=%0d got=%b exp=%b", k, bus.out_valid, 4'b0001 << (k % 4)); end
            total++; if (ch(bus.out_data, k % 4) !== 8'h10 + 8'(k)) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, ch(bus.out_data, k % 4), 8'h10 + 8'(k)); end
        end
        bus.in_valid = 1'b0;
        step();
        total++; if (rr_ptr !== 2'd0) begin bad++; $display("FAIL rr_ptr_wrap got=%0d exp=0", rr_ptr); end
        total++; if (xfer_cnt !== 16'd15) begin bad++; $display("FAIL rr_cnt got=%0d exp=15", xfer_cnt); end
    endtask

    task automatic test_mode_switch();
        bus.out_ready = 4'hF;
        bus.mode = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = 2'd3;
        bus.in_data = 8'h21; step();
        bus.in_data = 8'h22; step();
        total++; if (rr_ptr !== 2'd2) begin bad++; $display("FAIL ms_rr_two got=%0d exp=2", rr_ptr); end
        bus.mode = 1'b0; bus.in_sel = 2'd0; bus.in_data = 8'h30;
        step();
        total++; if (bus.out_valid !== 4'b0001 || ch(bus.out_data, 0) !== 8'h30) begin bad++; $display("FAIL ms_explicit got=%b/%h exp=0001/30", bus.out_valid, ch(bus.out_data, 0)); end
        total++; if (rr_ptr !== 2'd2) begin bad++; $display("FAIL ms_rr_hold got=%0d exp=2", rr_ptr); end
        bus.mode = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h40;
        step();
        total++; if (bus.out_valid !== 4'b0100 || ch(bus.out_data, 2) !== 8'h40) begin bad++; $display("FAIL ms_rr_resume got=%b/%h exp=0100/40", bus.out_valid, ch(bus.out_data, 2)); end
        total++; if (rr_ptr !== 2'd3) begin bad++; $display("FAIL ms_rr_final got=%0d exp=3", rr_ptr); end
        bus.in_valid = 1'b0;
        step();
        total++; if (xfer_cnt !== 16'd19) begin bad++; $display("FAIL ms_cnt got=%0d exp=19", xfer_cnt); end
    endtask

    task automatic test_reset_flush();
        bus.mode = 1'b0;
        bus.out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel = 2'(k);
            bus.in_data = 8'hC0 + 8'(k);
            step();
        end
        total++; if (bus.out_data !== 32'hC3C2C1C0 || bus.out_valid !== 4'hF) begin bad++; $display("FAIL flush_fill got=%b/%h exp=1111/c3c2c1c0", bus.out_valid, bus.out_data); end
        bus.in_sel = 2'd0;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_full_ready got=%b exp=0", bus.in_ready); end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (bus.out_valid !== 4'h0 || bus.out_data !== 32'h0) begin bad++; $display("FAIL flush_clear got=%b/%h exp=0000/0", bus.out_valid, bus.out_data); end
        total++; if (rr_ptr !== 2'd0 || xfer_cnt !== 16'd0) begin bad++; $display("FAIL flush_counters got=%0d/%0d exp=0/0", rr_ptr, xfer_cnt); end
        bus.out_ready = 4'hF;
        bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 8'h99;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 4'b1000 || ch(bus.out_data, 3) !== 8'h99) begin bad++; $display("FAIL flush_resume got=%b/%h exp=1000/99", bus.out_valid, ch(bus.out_data, 3)); end
        total++; if (xfer_cnt !== 16'd1) begin bad++; $display("FAIL flush_resume_cnt got=%0d exp=1", xfer_cnt); end
    endtask

    task automatic test_cnt_wrap();
        bus_w.mode = 1'b0;
        bus_w.out_ready = 4'hF;
        bus_w.in_sel = 2'd0;
        bus_w.in_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            bus_w.in_data = 8'(k);
            step();
            if (k == 15) begin
                total++; if (xfer_cnt_w !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", xfer_cnt_w); end
            end
            if (k == 16) begin
                total++; if (xfer_cnt_w !== 4'd0) begin bad++; $display("FAIL wrap_16 got=%0d exp=0", xfer_cnt_w); end
            end
        end
        bus_w.in_valid = 1'b0;
        total++; if (xfer_cnt_w !== 4'd1) begin bad++; $display("FAIL wrap_17 got=%0d exp=1", xfer_cnt_w); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_explicit();
        test_stall();
        test_round_robin();
        test_mode_switch();
        test_reset_flush();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
